// File: rtl/pipe_pkg.sv
// Shared types and constants for handshaked pipeline stage registers.
// Also holds the FSM encoding used when PIPE_STAGE_SKID_EN is defined.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  localparam logic [31:0] RV32I_NOP = 32'h00000013;

endpackage

// File: rtl/pipe_stall_ctr.sv
// Saturating back-pressure cycle counter, cleared only by rst.
module pipe_stall_ctr #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush and stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer variant.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             head_valid;
  logic [WIDTH-1:0] head_q, head_d;
  logic             in_xfer, out_xfer;

  assign out_valid = head_valid && !flush;
  assign out_data  = out_valid ? head_q : BUBBLE;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN

  pipe_state_t      state_q, state_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  // Ready derives only from registered state; rst gate keeps it low in reset.
  assign in_ready   = !rst && (state_q != PS_TWO);
  assign head_valid = (state_q != PS_EMPTY);
  assign occupancy  = state_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_xfer) begin
            head_d  = in_data;
            state_d = PS_ONE;
          end
        end
        PS_ONE: begin
          if (in_xfer && out_xfer) begin
            head_d = in_data;
          end else if (out_xfer) begin
            state_d = PS_EMPTY;
          end else if (in_xfer) begin
            skid_d  = in_data;
            state_d = PS_TWO;
          end
        end
        PS_TWO: begin
          if (out_xfer) begin
            head_d  = skid_q;
            state_d = PS_ONE;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PS_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`else

  logic vld_q, vld_d;

  assign in_ready   = !rst && (!vld_q || out_ready);
  assign head_valid = vld_q;
  assign occupancy  = {1'b0, vld_q};

  always_comb begin
    vld_d  = vld_q;
    head_d = head_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (in_xfer) begin
      head_d = in_data;
      vld_d  = 1'b1;
    end else if (out_xfer) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      head_q <= '0;
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
    end
  end

`endif

  pipe_stall_ctr #(.CNT_W(CNT_W)) u_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready),
    .count (stall_cnt)
  );

endmodule
